// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// default byte width, grant index width and a counter-width helper.
package uart_ctrl_defs;

  localparam int DATA_W_DEF = 8;
  localparam int GID_W      = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } arb_state_e;

  // Bits needed to count from 0 up to maxv (at least one bit).
  function automatic int cnt_w(input int maxv);
    return (maxv > 1) ? $clog2(maxv + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin select: first asserted request after ptr,
// wrapping modulo N. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Scan ptr+1, ptr+2, ... and stop at the first live request.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_core transmitter between NUM_REQ byte streams.
// Round-robin between messages; a requester keeps the grant until it
// sends a byte flagged last (or stalls past HOLD_TIMEOUT).
module uart_tx_arbiter
  import uart_ctrl_defs::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int START_TIMEOUT = 16,
  parameter int HOLD_TIMEOUT  = 1024
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data_in,
  input  logic                        tx_busy,
  output logic [GID_W-1:0]            grant_id,
  output logic                        locked,
  output logic                        err_start_to,
  output logic                        err_hold_to
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = cnt_w(START_TIMEOUT);
  localparam int HW = cnt_w(HOLD_TIMEOUT);
  localparam logic [SW-1:0] S_LAST = SW'(START_TIMEOUT - 1);
  localparam logic [HW-1:0] H_LAST = HW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [IW-1:0]     gid_q,   gid_d;
  logic [IW-1:0]     rr_q,    rr_d;
  logic              lock_q,  lock_d;
  logic [SW-1:0]     scnt_q,  scnt_d;
  logic [HW-1:0]     hcnt_q,  hcnt_d;
  logic              est_q,   est_d;
  logic              eht_q,   eht_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign tx_data_in   = data_q;
  assign grant_id     = GID_W'(gid_q);
  assign locked       = lock_q;
  assign err_start_to = est_q;
  assign err_hold_to  = eht_q;

  // State and datapath registers; everything clears on rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      data_q  <= '0;
      gid_q   <= '0;
      rr_q    <= IW'(NUM_REQ - 1);
      lock_q  <= 1'b0;
      scnt_q  <= '0;
      hcnt_q  <= '0;
      est_q   <= 1'b0;
      eht_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      scnt_q  <= scnt_d;
      hcnt_q  <= hcnt_d;
      est_q   <= est_d;
      eht_q   <= eht_d;
    end
  end

  // Next-state, handshake and launch decode.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    gid_d     = gid_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    scnt_d    = scnt_q;
    hcnt_d    = hcnt_q;
    est_d     = est_q;
    eht_d     = eht_q;
    req_ready = '0;
    tx_start  = 1'b0;

    case (state_q)
      IDLE: begin
        // No new grant while the UART is still shifting something out.
        if (arb_any && !tx_busy) begin
          req_ready = arb_gnt;
          data_d    = req_data[arb_idx*DATA_W +: DATA_W];
          gid_d     = arb_idx;
          lock_d    = ~req_last[arb_idx];
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        scnt_d   = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A byte that never starts is dropped, not retried.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (scnt_q == S_LAST) begin
          est_d   = 1'b1;
          state_d = WAIT_DONE;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock_q) begin
            hcnt_d  = '0;
            state_d = HOLD;
          end else begin
            rr_d    = gid_q;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        // Only the lock owner may continue its message.
        if (!tx_busy && req_valid[gid_q]) begin
          req_ready[gid_q] = 1'b1;
          data_d  = req_data[gid_q*DATA_W +: DATA_W];
          lock_d  = ~req_last[gid_q];
          state_d = LAUNCH;
        end else if (HOLD_TIMEOUT != 0 && hcnt_q == H_LAST) begin
          eht_d   = 1'b1;
          lock_d  = 1'b0;
          rr_d    = gid_q;
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART busy model, per-requester
// byte queues, and a scoreboard of expected {byte, locked} per tx_start.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data_in;
  logic            tx_busy;
  logic [2:0]      grant_id;
  logic            locked;
  logic            err_start_to;
  logic            err_hold_to;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .START_TIMEOUT(16), .HOLD_TIMEOUT(1024)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_busy(tx_busy), .grant_id(grant_id),
    .locked(locked), .err_start_to(err_start_to), .err_hold_to(err_hold_to)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // UART model: busy rises 2 cycles after tx_start, stays high 12 cycles.
  int m_cnt;
  bit dead = 1'b0;
  bit force_busy = 1'b0;
  always @(posedge clk or negedge rstn)
    if (!rstn) m_cnt <= 0;
    else if (tx_start && !dead) m_cnt <= 14;
    else if (m_cnt != 0) m_cnt <= m_cnt - 1;
  assign tx_busy = force_busy | (m_cnt >= 1 && m_cnt <= 12);

  // Scoreboard: expected bytes in launch order.
  typedef struct { logic [7:0] d; logic lk; } exp_t;
  exp_t sb[$];
  int   n_start = 0;
  int   last_start_cyc = 0;

  task automatic exp_push(input logic [7:0] d, input logic lk);
    exp_t e;
    e.d = d; e.lk = lk;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rstn && tx_start) begin
      exp_t e;
      n_start++;
      last_start_cyc = cyc;
      chk("start_while_busy", {31'd0, tx_busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_start", {24'd0, tx_data_in}, 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("tx_data", {24'd0, tx_data_in}, {24'd0, e.d});
        chk("locked_at_start", {31'd0, locked}, {31'd0, e.lk});
      end
    end
  end

  // Requester driver: presents queue heads, pops on handshake.
  typedef struct { logic [7:0] d; logic l; } byte_t;
  byte_t rq[NR][$];
  bit drv_en = 1'b0;
  logic [NR-1:0] acc = '0;

  task automatic offer(input int r, input logic [7:0] d, input logic l);
    byte_t b;
    b.d = d; b.l = l;
    rq[r].push_back(b);
  endtask

  initial forever begin
    @(negedge clk);
    if (!drv_en) begin
      acc = '0;
    end else begin
      for (int i = 0; i < NR; i++) if (acc[i]) void'(rq[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = rq[i][0].d;
          req_last[i] = rq[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i] = 1'b0;
        end
      end
      #1;
      acc = req_valid & req_ready;
      if (req_ready != '0) chk("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return sb.size() == 0;
  endfunction

  task automatic do_reset();
    drv_en = 1'b0;
    @(negedge clk); #2;
    req_valid = '0; req_last = '0; req_data = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk); #2;
      if (all_empty() && m_cnt == 0 && !tx_busy) done = 1'b1;
    end
    chk("drain_in_time", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_locked(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (locked) done = 1'b1;
    end
    chk("lock_in_time", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_sb_empty(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk); #2;
      if (sb.size() == 0) done = 1'b1;
    end
    chk("launch_in_time", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_tx_data"},  {24'd0, tx_data_in}, 32'd0);
    chk({tag, "_ready"},    {28'd0, req_ready}, 32'd0);
    chk({tag, "_grant"},    {29'd0, grant_id}, 32'd0);
    chk({tag, "_locked"},   {31'd0, locked}, 32'd0);
    chk({tag, "_err_st"},   {31'd0, err_start_to}, 32'd0);
    chk({tag, "_err_ht"},   {31'd0, err_hold_to}, 32'd0);
  endtask

  // Combinational ready vectors straight after reset (rr_ptr = 3).
  typedef struct { logic [3:0] valid; logic busy; logic [3:0] exp; } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0, f;
    bit ok;
    rstn = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    #1 rstn = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");

    tbl[0] = '{4'b0001, 1'b0, 4'b0001};
    tbl[1] = '{4'b0110, 1'b0, 4'b0010};
    tbl[2] = '{4'b1100, 1'b0, 4'b0100};
    tbl[3] = '{4'b1000, 1'b0, 4'b1000};
    tbl[4] = '{4'b1111, 1'b0, 4'b0001};
    tbl[5] = '{4'b0000, 1'b0, 4'b0000};
    tbl[6] = '{4'b1111, 1'b1, 4'b0000};
    tbl[7] = '{4'b1010, 1'b0, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid; force_busy = tbl[i].busy;
      #1 chk($sformatf("vec%0d_ready", i), {28'd0, req_ready}, {28'd0, tbl[i].exp});
      req_valid = '0; force_busy = 1'b0;
    end

    // Single byte from requester 1: one-cycle ready, launch next cycle.
    @(negedge clk);
    req_valid = 4'b0010; req_data[15:8] = 8'h41; req_last = 4'b0010;
    exp_push(8'h41, 1'b0);
    #1 chk("s1_ready", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1 chk("s1_tx_start", {31'd0, tx_start}, 32'd1);
    chk("s1_tx_data", {24'd0, tx_data_in}, 32'h41);
    chk("s1_ready_drop", {28'd0, req_ready}, 32'd0);
    wait_drain(200);
    chk("s1_grant", {29'd0, grant_id}, 32'd1);
    chk("s1_locked", {31'd0, locked}, 32'd0);
    @(negedge clk);
    req_valid = 4'b0011;
    #1 chk("s1_rr_after", {28'd0, req_ready}, 32'h1);
    req_valid = '0;

    // Three simultaneous single-byte requesters.
    do_reset();
    offer(0, 8'hA0, 1'b1); offer(2, 8'hA2, 1'b1); offer(3, 8'hA3, 1'b1);
    exp_push(8'hA0, 1'b0); exp_push(8'hA2, 1'b0); exp_push(8'hA3, 1'b0);
    s0 = n_start;
    drv_en = 1'b1;
    wait_drain(400);
    chk("s2_start_count", n_start - s0, 32'd3);

    // "OK\n" from requester 2 must not be interleaved by requester 0.
    offer(2, 8'h4F, 1'b0); offer(2, 8'h4B, 1'b0); offer(2, 8'h0A, 1'b1);
    exp_push(8'h4F, 1'b1); exp_push(8'h4B, 1'b1); exp_push(8'h0A, 1'b0);
    wait_locked(50);
    offer(0, 8'h30, 1'b1);
    exp_push(8'h30, 1'b0);
    wait_drain(600);
    chk("s3_grant", {29'd0, grant_id}, 32'd0);

    // Requester 3 stalls mid-message; lock drops after HOLD_TIMEOUT.
    offer(3, 8'h55, 1'b0);
    exp_push(8'h55, 1'b1);
    wait_locked(50);
    offer(1, 8'h31, 1'b1);
    exp_push(8'h31, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); if (tx_busy) ok = 1'b1; end
    chk("s4_busy_rise", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); if (!tx_busy) ok = 1'b1; end
    chk("s4_busy_fall", {31'd0, ok}, 32'd1);
    f = cyc;
    while (cyc < f + 1000) @(negedge clk);
    chk("s4_err_ht_early", {31'd0, err_hold_to}, 32'd0);
    chk("s4_locked_early", {31'd0, locked}, 32'd1);
    chk("s4_waiting", sb.size(), 32'd1);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); if (err_hold_to) ok = 1'b1; end
    chk("s4_err_ht", {31'd0, err_hold_to}, 32'd1);
    wait_drain(200);
    chk("s4_grant", {29'd0, grant_id}, 32'd1);
    chk("s4_locked", {31'd0, locked}, 32'd0);
    chk("s4_err_st", {31'd0, err_start_to}, 32'd0);

    // Dead UART: tx_busy never rises, start timeout fires, flow continues.
    do_reset();
    chk("s5_err_ht_cleared", {31'd0, err_hold_to}, 32'd0);
    dead = 1'b1;
    offer(0, 8'h10, 1'b1);
    exp_push(8'h10, 1'b0);
    drv_en = 1'b1;
    wait_sb_empty(50);
    c0 = last_start_cyc;
    while (cyc < c0 + 15) @(negedge clk);
    chk("s5_err_st_early", {31'd0, err_start_to}, 32'd0);
    repeat (2) @(negedge clk);
    chk("s5_err_st", {31'd0, err_start_to}, 32'd1);
    offer(1, 8'h11, 1'b1);
    exp_push(8'h11, 1'b0);
    wait_drain(200);
    chk("s5_err_sticky", {31'd0, err_start_to}, 32'd1);
    chk("s5_grant", {29'd0, grant_id}, 32'd1);
    dead = 1'b0;

    // Reset in the middle of a 3-byte message.
    do_reset();
    offer(2, 8'hC1, 1'b0); offer(2, 8'hC2, 1'b0); offer(2, 8'hC3, 1'b1);
    exp_push(8'hC1, 1'b1);
    drv_en = 1'b1;
    wait_sb_empty(50);
    repeat (3) @(negedge clk);
    #2 drv_en = 1'b0;
    req_valid = '0; req_last = '0;
    chk("s6_locked_pre", {31'd0, locked}, 32'd1);
    chk("s6_grant_pre", {29'd0, grant_id}, 32'd2);
    rstn = 1'b0;
    #1 chk_reset_vals("s6_rst");
    repeat (3) @(negedge clk);
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    #2 rstn = 1'b1;
    @(negedge clk);
    offer(3, 8'h5B, 1'b1); offer(0, 8'h5A, 1'b1);
    exp_push(8'h5A, 1'b0); exp_push(8'h5B, 1'b0);
    drv_en = 1'b1;
    wait_drain(400);
    chk("s6_grant", {29'd0, grant_id}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
